// File: rtl/monocicle_pkg.sv
// Shared register-file writeback types: index/data widths and the queued write entry.
package monocicle_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO for load writebacks with an entry view for hazard and kill compares.
// WB_WAW_KILL_EN adds per-entry live bits that a younger ALU write to the same rd clears.
module wb_fifo
  import monocicle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   kill_valid,
  input  logic [REG_ADDR_W-1:0]  kill_rd,
  output wb_entry_t              head_entry,
  output logic                   head_live,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       view_valid,
  output wb_entry_t [DEPTH-1:0]  view_entry
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0]    mem_q, mem_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]              count_q, count_d;
  logic [DEPTH-1:0][PW-1:0] off_s;
  logic [DEPTH-1:0]         occ_s;

  // A slot is occupied when its distance past the read pointer is below count.
  always_comb begin
    off_s = '0;
    occ_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = PW'(i) - rd_ptr_q;
      occ_s[i] = ({1'b0, off_s[i]} < count_q);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef WB_WAW_KILL_EN
  logic [DEPTH-1:0] live_q, live_d;

  // Kill applies to entries already queued; the entry pushed this edge is younger and stays live.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      live_d[i] = (kill_valid && occ_s[i] && (mem_q[i].rd == kill_rd)) ? 1'b0 : live_q[i];
    end
    live_d[wr_ptr_q] = push ? 1'b1 : live_d[wr_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
    end else begin
      live_q <= live_d;
    end
  end

  assign head_live  = live_q[rd_ptr_q];
  assign view_valid = occ_s & live_q;
`else
  logic unused_kill_s;
  assign unused_kill_s = kill_valid ^ (^kill_rd);
  assign head_live     = 1'b1;
  assign view_valid    = occ_s;
`endif

  assign head_entry = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == (PW+1)'(DEPTH));
  assign count      = count_q;
  assign view_entry = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Merges the ALU and buffered load writebacks into one registered register-file write per cycle.
// WB_WAW_KILL_EN: a selected ALU write cancels queued loads to the same rd.
module regfile_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hit1,
  output logic              hit2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writeData
);
  import monocicle_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_sel_s, fifo_sel_s, push_s;
  logic                  head_live_s, empty_s, full_s;
  logic                  hit1_s, hit2_s;
  wb_entry_t             head_s, push_entry_s;
  logic [CW-1:0]         unused_count_s;
  logic [DEPTH-1:0]      view_valid_s;
  wb_entry_t [DEPTH-1:0] view_entry_s;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Ready never looks at this cycle's pop, so a full queue stalls the load source for a cycle.
  assign lsu_ready    = !full_s && !rst;
  assign push_s       = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);
  assign push_entry_s = '{rd: lsu_rd, data: lsu_data};
  assign alu_sel_s    = alu_valid && (alu_rd != REG_ZERO);
  assign fifo_sel_s   = !alu_sel_s && !empty_s;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (fifo_sel_s),
    .kill_valid (alu_sel_s),
    .kill_rd    (alu_rd),
    .head_entry (head_s),
    .head_live  (head_live_s),
    .empty      (empty_s),
    .full       (full_s),
    .count      (unused_count_s),
    .view_valid (view_valid_s),
    .view_entry (view_entry_s)
  );

  // A killed head is still popped but produces no write; rd/data hold when idle.
  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (alu_sel_s) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      wdata_d    = alu_data;
    end else if (fifo_sel_s && head_live_s) begin
      regwrite_d = 1'b1;
      rd_d       = head_s.rd;
      wdata_d    = head_s.data;
    end else begin
      regwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    hit1_s = regwrite_q && (rd_q == rs1);
    hit2_s = regwrite_q && (rd_q == rs2);
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s = hit1_s || (view_valid_s[i] && (view_entry_s[i].rd == rs1));
      hit2_s = hit2_s || (view_valid_s[i] && (view_entry_s[i].rd == rs2));
    end
  end

  assign hit1      = hit1_s && (rs1 != REG_ZERO);
  assign hit2      = hit2_s && (rs2 != REG_ZERO);
  assign regWrite  = regwrite_q;
  assign rd        = rd_q;
  assign writeData = wdata_q;

endmodule
